div_ratio_detector: RTL

- Receive-side companion to the team's flip-flop clock dividers: takes a divided clock back into the fast domain and recovers its division ratio.
- Samples the divided clock with the source clock, measures its period and high time in clk cycles, and reports the ratio.
- Declares lock after a run of consistent periods and flags drift or loss of the divided clock.
- Sits beside divider chains as a self-check and monitor.

---
 rtl/div_ratio_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 34 +++
 rtl/div_ratio_detector.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_ratio_pkg.sv
// Shared types and helpers for the divided-clock ratio detector.
package div_ratio_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_e;

    // All-ones value for a counter of the given width (widths up to 32).
    function automatic logic [31:0] cnt_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with registered rise/fall pulses; the level output is
// delayed to line up with the pulses.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q, level_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            rise_q  <= sync2_q & ~level_q;
            fall_q  <= ~sync2_q & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/div_ratio_detector.sv
// Recovers the division ratio of a divided clock sampled in the fast domain,
// tracks lock and flags drift (err) or a stuck input (ovf).
module div_ratio_detector
    import div_ratio_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TOL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             clr,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic             ratio_valid,
    output logic             locked,
    output logic             err,
    output logic             ovf
);

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(cnt_max(CNT_W));
    localparam int unsigned        MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W:0]     TOL_V      = (CNT_W + 1)'(TOL);

    logic level, rise, fall;

    sync_edge_det u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (div_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0]   ref_q, ref_d, ratio_q, ratio_d, high_q, high_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic               valid_q, valid_d, locked_q, locked_d, err_q, err_d, ovf_q, ovf_d;
    state_e             state_q, state_d;

    logic [CNT_W:0] diff;
    logic           in_tol, sat;

    assign diff = (per_cnt_q >= ref_q) ? ({1'b0, per_cnt_q} - {1'b0, ref_q})
                                       : ({1'b0, ref_q} - {1'b0, per_cnt_q});
    assign in_tol    = (diff <= TOL_V);
    assign match_inc = match_q + 1'b1;
    // A rise in idle with a saturated counter is the restart edge, not a new overflow.
    assign sat = (per_cnt_q == CNT_MAX) && !(rise && (state_q == S_IDLE));

    always_comb begin
        per_cnt_d = rise ? CNT_W'(1) :
                    (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
        hi_cnt_d  = rise ? CNT_W'(1) :
                    (level && (hi_cnt_q != CNT_MAX)) ? hi_cnt_q + 1'b1 : hi_cnt_q;
        hi_hold_d = fall ? hi_cnt_q : hi_hold_q;
        state_d   = state_q;
        ref_d     = ref_q;
        match_d   = match_q;
        ratio_d   = ratio_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        err_d     = err_q;
        ovf_d     = ovf_q;

        if (clr) begin
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            hi_hold_d = '0;
            state_d   = S_IDLE;
            ref_d     = '0;
            match_d   = '0;
            ratio_d   = '0;
            high_d    = '0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
            ovf_d     = 1'b0;
        end else if (sat) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = S_IDLE;
        end else if (rise) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    match_d = '0;
                end
                S_ACQ: begin
                    ratio_d = per_cnt_q;
                    high_d  = hi_hold_q;
                    valid_d = 1'b1;
                    if ((match_q == '0) || !in_tol) begin
                        ref_d   = per_cnt_q;
                        match_d = MATCH_W'(1);
                    end else begin
                        match_d = match_inc;
                        if (match_inc == MATCH_LOCK) begin
                            state_d  = S_LOCK;
                            locked_d = 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    ratio_d = per_cnt_q;
                    high_d  = hi_hold_q;
                    valid_d = 1'b1;
                    if (!in_tol) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        ref_d    = per_cnt_q;
                        match_d  = MATCH_W'(1);
                        state_d  = S_ACQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            hi_hold_q <= '0;
            state_q   <= S_IDLE;
            ref_q     <= '0;
            match_q   <= '0;
            ratio_q   <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            hi_hold_q <= hi_hold_d;
            state_q   <= state_d;
            ref_q     <= ref_d;
            match_q   <= match_d;
            ratio_q   <= ratio_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ratio       = ratio_q;
    assign high_cnt    = high_q;
    assign ratio_valid = valid_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign ovf         = ovf_q;

endmodule
